pipe_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Takes per-stage stall requests and the MEM-stage exception/ERET request. Drives the stall and flush inputs of every inter-stage register (IF_ID and downstream) and the PC redirect into the fetch unit.
- Holds a pending redirect when fetch cannot accept it, so a flush is never lost.
- Keeps a stall-cycle performance counter.

---
 rtl/pipe_ctrl_if.sv | 30 +++
 rtl/pipe_ctrl.sv | 86 ++++++++
 tb/tb_pipe_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Stall/flush control bundle between the pipeline stages and the central sequencer.
// The master side is the sequencer; the slave side is the pipeline/fetch logic.
interface pipe_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
);
    logic              if_stallreq;
    logic              id_stallreq;
    logic              ex_stallreq;
    logic              mem_stallreq;
    logic              excp_req;
    logic [ADDR_W-1:0] excp_target;
    logic [4:0]        stall;
    logic              flush;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic [CNT_W-1:0]  stall_cycles;

    modport master (
        input  if_stallreq, id_stallreq, ex_stallreq, mem_stallreq,
        input  excp_req, excp_target,
        output stall, flush, redirect_valid, redirect_pc, stall_cycles
    );

    modport slave (
        output if_stallreq, id_stallreq, ex_stallreq, mem_stallreq,
        output excp_req, excp_target,
        input  stall, flush, redirect_valid, redirect_pc, stall_cycles
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Central stall/flush sequencer for the IF/ID/EX/MEM/WB pipeline: stall priority,
// exception flush with a held fetch redirect, and a stall-cycle counter.
module pipe_ctrl #(
    parameter int CNT_W  = 32,
    parameter int ADDR_W = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    pipe_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        RUN        = 2'b00,
        FLUSH      = 2'b01,
        REDIR_WAIT = 2'b10
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [4:0]        stall_run;
    logic [4:0]        stall_c;
    logic              flush_c;
    logic              redir_c;
    logic              accept;
    logic [ADDR_W-1:0] redirect_pc_r;
    logic [CNT_W-1:0]  stall_cnt;

    // Oldest requesting stage wins; everything younger than it is held too.
    always_comb begin
        stall_run = 5'b00000;
        if (bus.mem_stallreq)
            stall_run = 5'b01111;
        else if (bus.ex_stallreq)
            stall_run = 5'b00111;
        else if (bus.id_stallreq)
            stall_run = 5'b00011;
        else if (bus.if_stallreq)
            stall_run = 5'b00001;
    end

    always_comb begin
        state_nxt = RUN;
        stall_c   = 5'b00000;
        flush_c   = 1'b0;
        redir_c   = 1'b0;
        accept    = 1'b0;
        case (state)
            RUN: begin
                stall_c   = stall_run;
                accept    = bus.excp_req & ~bus.mem_stallreq;
                state_nxt = accept ? FLUSH : RUN;
            end
            FLUSH: begin
                flush_c   = 1'b1;
                redir_c   = 1'b1;
                state_nxt = bus.if_stallreq ? REDIR_WAIT : RUN;
            end
            REDIR_WAIT: begin
                redir_c   = 1'b1;
                stall_c   = 5'b00001;
                state_nxt = bus.if_stallreq ? REDIR_WAIT : RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RUN;
            redirect_pc_r <= '0;
            stall_cnt     <= '0;
        end else begin
            state <= state_nxt;
            if (accept)
                redirect_pc_r <= bus.excp_target;
            if (bus.stall != 5'b00000)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // Stall is combinational on the requests, so it must be masked explicitly during reset.
    assign bus.stall          = rst_n ? stall_c : 5'b00000;
    assign bus.flush          = flush_c;
    assign bus.redirect_valid = redir_c;
    assign bus.redirect_pc    = redirect_pc_r;
    assign bus.stall_cycles   = stall_cnt;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl; a narrow counter lets the wrap case run in a few cycles.
module tb_pipe_ctrl;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    pipe_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    pipe_ctrl #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic i_if, input logic i_id, input logic i_ex, input logic i_mem,
                         input logic i_exc, input logic [ADDR_W-1:0] tgt);
        bus.if_stallreq  = i_if;
        bus.id_stallreq  = i_id;
        bus.ex_stallreq  = i_ex;
        bus.mem_stallreq = i_mem;
        bus.excp_req     = i_exc;
        bus.excp_target  = tgt;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic outs(input string tag, input logic [4:0] st, input logic fl, input logic rv);
        check({tag, "_stall"}, 64'(bus.stall), 64'(st));
        check({tag, "_flush"}, 64'(bus.flush), 64'(fl));
        check({tag, "_rv"},    64'(bus.redirect_valid), 64'(rv));
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1, 1, 1, 1, 1, 32'hDEAD_BEEF);
        tick();
        tick();
        outs("rst", 5'b00000, 0, 0);
        check("rst_cnt", 64'(bus.stall_cycles), 64'd0);
        check("rst_pc", 64'(bus.redirect_pc), 64'd0);

        rst_n = 1'b1;
        #1;
        check("rel_stall", 64'(bus.stall), 64'(5'b01111));
        check("rel_flush", 64'(bus.flush), 64'd0);
        drive(0, 0, 0, 0, 0, 32'h0);
        tick();
        check("rel_cnt", 64'(bus.stall_cycles), 64'd0);

        // Priority encoding, one counted cycle each
        drive(0, 1, 0, 0, 0, 32'h0);
        check("pri_id", 64'(bus.stall), 64'(5'b00011));
        tick();
        drive(0, 1, 1, 0, 0, 32'h0);
        check("pri_idex", 64'(bus.stall), 64'(5'b00111));
        tick();
        drive(1, 0, 0, 0, 0, 32'h0);
        check("pri_if", 64'(bus.stall), 64'(5'b00001));
        tick();
        drive(1, 1, 1, 1, 0, 32'h0);
        check("pri_all", 64'(bus.stall), 64'(5'b01111));
        drive(0, 0, 0, 0, 0, 32'h0);
        check("pri_none", 64'(bus.stall), 64'(5'b00000));
        check("pri_cnt", 64'(bus.stall_cycles), 64'd3);

        // Plain exception; a stall request during FLUSH is overridden and not counted
        drive(0, 0, 0, 0, 1, 32'hBFC0_0380);
        outs("exc_acc", 5'b00000, 0, 0);
        tick();
        drive(0, 1, 0, 0, 0, 32'h0);
        outs("exc_fl", 5'b00000, 1, 1);
        check("exc_pc", 64'(bus.redirect_pc), 64'h0000_0000_BFC0_0380);
        tick();
        drive(0, 0, 0, 0, 1, 32'h8000_0180);
        outs("exc_after", 5'b00000, 0, 0);
        check("exc_cnt", 64'(bus.stall_cycles), 64'd3);
        tick();
        drive(0, 0, 0, 0, 0, 32'h0);
        outs("b2b_fl", 5'b00000, 1, 1);
        check("b2b_pc", 64'(bus.redirect_pc), 64'h0000_0000_8000_0180);
        tick();
        outs("b2b_after", 5'b00000, 0, 0);

        // Exception held off by a MEM stall for 4 cycles
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 1, 1, 32'hBFC0_0380);
            outs("mem_hold", 5'b01111, 0, 0);
            tick();
        end
        check("mem_cnt", 64'(bus.stall_cycles), 64'd7);
        drive(0, 0, 0, 0, 1, 32'hBFC0_0380);
        outs("mem_rel", 5'b00000, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 32'h0);
        outs("mem_fl", 5'b00000, 1, 1);
        check("mem_pc", 64'(bus.redirect_pc), 64'h0000_0000_BFC0_0380);
        tick();
        check("mem_cnt2", 64'(bus.stall_cycles), 64'd7);

        // Redirect held while fetch is busy; a second exception is ignored
        drive(0, 0, 0, 0, 1, 32'hBFC0_0380);
        tick();
        drive(1, 0, 0, 0, 0, 32'h0);
        outs("rw_fl", 5'b00000, 1, 1);
        tick();
        drive(1, 1, 1, 1, 1, 32'h8000_0180);
        outs("rw_w1", 5'b00001, 0, 1);
        tick();
        drive(1, 0, 0, 0, 0, 32'h0);
        outs("rw_w2", 5'b00001, 0, 1);
        check("rw_pc", 64'(bus.redirect_pc), 64'h0000_0000_BFC0_0380);
        tick();
        drive(0, 0, 0, 0, 0, 32'h0);
        outs("rw_w3", 5'b00001, 0, 1);
        tick();
        outs("rw_done", 5'b00000, 0, 0);
        check("rw_pc2", 64'(bus.redirect_pc), 64'h0000_0000_BFC0_0380);
        check("rw_cnt", 64'(bus.stall_cycles), 64'd10);
        tick();
        check("rw_noflush", 64'(bus.flush), 64'd0);

        // Counter wrap on the 4-bit counter
        drive(0, 0, 1, 0, 0, 32'h0);
        repeat (5) tick();
        check("wrap_max", 64'(bus.stall_cycles), 64'd15);
        tick();
        check("wrap_zero", 64'(bus.stall_cycles), 64'd0);
        tick();
        check("wrap_one", 64'(bus.stall_cycles), 64'd1);

        // Reset pulse while waiting on fetch
        drive(0, 0, 0, 0, 1, 32'h1234_5678);
        tick();
        drive(1, 0, 0, 0, 0, 32'h0);
        tick();
        outs("rr_wait", 5'b00001, 0, 1);
        rst_n = 1'b0;
        #1;
        outs("rr_rst", 5'b00000, 0, 0);
        check("rr_pc", 64'(bus.redirect_pc), 64'd0);
        check("rr_cnt", 64'(bus.stall_cycles), 64'd0);
        tick();
        rst_n = 1'b1;
        drive(0, 1, 0, 0, 0, 32'h0);
        outs("rr_run", 5'b00011, 0, 0);
        tick();
        check("rr_cnt2", 64'(bus.stall_cycles), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
